// File: rtl/machina_pkg.sv
// Shared definitions for the accumulate datapath: state encoding and default widths.
package machina_pkg;

    typedef enum logic [0:0] {
        ACC = 1'b0,
        OUT = 1'b1
    } acc_state_e;

    localparam int ARGW_DEFAULT = 32;
    localparam int RESW_DEFAULT = 32;
    localparam int N_DEFAULT    = 4;

endpackage

// File: rtl/saturate_add.sv
// Combinational signed adder that clamps to the representable range and flags the clamp.
module saturate_add #(
    parameter int RESW = 32
) (
    input  logic signed [RESW-1:0] a,
    input  logic signed [RESW-1:0] b,
    output logic signed [RESW-1:0] sum,
    output logic                   overflow
);

    localparam logic signed [RESW-1:0] MAXV = {1'b0, {(RESW-1){1'b1}}};
    localparam logic signed [RESW-1:0] MINV = {1'b1, {(RESW-1){1'b0}}};

    logic signed [RESW-1:0] raw;

    always_comb begin
        raw      = a + b;
        // Overflow only when both operands share a sign the wrapped result lost.
        overflow = (a[RESW-1] == b[RESW-1]) && (raw[RESW-1] != a[RESW-1]);
        sum      = overflow ? (a[RESW-1] ? MINV : MAXV) : raw;
    end

endmodule

// File: rtl/accumulate.sv
// Collects up to N signed terms into a saturating sum, then holds the result until consumed.
module accumulate
    import machina_pkg::*;
#(
    parameter int ARGW = ARGW_DEFAULT,
    parameter int RESW = RESW_DEFAULT,
    parameter int N    = N_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arg_valid,
    input  logic signed [ARGW-1:0] arg_data,
    input  logic                   arg_last,
    output logic                   arg_ready,
    output logic                   res_valid,
    output logic signed [RESW-1:0] res_data,
    output logic                   res_sat,
    input  logic                   res_ready
);

    localparam int CW = $clog2(N + 1);

    acc_state_e             state_reg;
    logic [CW-1:0]          cnt_reg;
    logic signed [RESW-1:0] sum_reg;
    logic                   sat_reg;

    logic                   accept;
    logic                   close_sum;
    logic signed [RESW-1:0] term_ext;
    logic signed [RESW-1:0] add_sum;
    logic                   add_ovf;

    assign term_ext  = RESW'(arg_data);
    assign arg_ready = (state_reg == ACC);
    assign res_valid = (state_reg == OUT);
    assign accept    = arg_valid && arg_ready;
    // The Nth term and an early arg_last close the same sum, so only one result results.
    assign close_sum = arg_last || (cnt_reg == CW'(N - 1));

    // The held sum doubles as the result register; it is frozen while in OUT.
    assign res_data  = sum_reg;
    assign res_sat   = sat_reg;

    saturate_add #(
        .RESW(RESW)
    ) u_saturate_add (
        .a       (sum_reg),
        .b       (term_ext),
        .sum     (add_sum),
        .overflow(add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACC;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            sat_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ACC: begin
                    if (accept) begin
                        sum_reg <= add_sum;
                        sat_reg <= sat_reg | add_ovf;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (close_sum) begin
                            state_reg <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        state_reg <= ACC;
                        cnt_reg   <= '0;
                        sum_reg   <= '0;
                        sat_reg   <= 1'b0;
                    end
                end
                default: state_reg <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulate.sv
// Self-checking bench for accumulate: vector table, handshake/reset corner sequences, random run vs model.
module tb_accumulate;

    localparam int N = 4;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clk;
    logic        rst_n;
    logic        arg_valid;
    logic [31:0] arg_data;
    logic        arg_last;
    logic        arg_ready;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_sat;
    logic        res_ready;

    int checks = 0;
    int errors = 0;

    accumulate #(.ARGW(32), .RESW(32), .N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arg_valid(arg_valid),
        .arg_data (arg_data),
        .arg_last (arg_last),
        .arg_ready(arg_ready),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_sat  (res_sat),
        .res_ready(res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0][31:0] t;
        logic [3:0]       last;
        int               n;
        logic [31:0]      d;
        logic             s;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] t0, input logic [31:0] t1,
                                input logic [31:0] t2, input logic [31:0] t3,
                                input logic [3:0] last, input int n,
                                input logic [31:0] d, input logic s);
        vec_t v;
        v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = t3;
        v.last = last; v.n = n; v.d = d; v.s = s;
        return v;
    endfunction

    // Reference: plain wide arithmetic clamped after every term.
    function automatic void model_sum(input logic [31:0] q[$], output logic [31:0] d, output logic s);
        longint acc = 0;
        s = 1'b0;
        foreach (q[i]) begin
            acc = acc + longint'($signed(q[i]));
            if (acc > MAXV) begin acc = MAXV; s = 1'b1; end
            if (acc < MINV) begin acc = MINV; s = 1'b1; end
        end
        d = acc[31:0];
    endfunction

    function automatic logic [31:0] rand_term();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return 32'($urandom_range(0, 255)) - 32'd128;
            2:       return 32'h7fff_ff00 + 32'($urandom_range(0, 255));
            default: return 32'h8000_0000 + 32'($urandom_range(0, 255));
        endcase
    endfunction

    vec_t vecs[8];

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_d;
        logic        exp_s;
        logic        pending;
        int          sums_done;
        int          cycles;

        vecs[0] = mk(32'h4000, 32'h4000, 32'h4000, 32'h4000, 4'b0000, 4, 32'h10000, 1'b0);
        vecs[1] = mk(32'h4000, 32'h10000, 32'h0, 32'h0, 4'b0010, 2, 32'h14000, 1'b0);
        vecs[2] = mk(32'h1, 32'h1, 32'h1, 32'h1, 4'b0000, 4, 32'h4, 1'b0);
        vecs[3] = mk(32'h7fffffff, 32'h1, 32'h0, 32'h0, 4'b0000, 4, 32'h7fffffff, 1'b1);
        vecs[4] = mk(32'h80000000, 32'hffffffff, 32'h0, 32'h0, 4'b0000, 4, 32'h80000000, 1'b1);
        vecs[5] = mk(32'h7fffffff, 32'h1, 32'hffffffff, 32'h0, 4'b0000, 4, 32'h7ffffffe, 1'b1);
        vecs[6] = mk(32'h5, 32'h0, 32'h0, 32'h0, 4'b0001, 1, 32'h5, 1'b0);
        vecs[7] = mk(32'h1, 32'h2, 32'h3, 32'h4, 4'b1000, 4, 32'ha, 1'b0);

        rst_n = 1'b0; arg_valid = 1'b0; arg_data = '0; arg_last = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_arg_ready", 32'(arg_ready), 32'd1);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_res_data", res_data, 32'd0);
        check("reset_res_sat", 32'(res_sat), 32'd0);
        rst_n = 1'b1;

        // Table-driven sums with the consumer always ready.
        res_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                @(negedge clk);
                if (k > 0) check("no_early_result", 32'(res_valid), 32'd0);
                arg_valid = 1'b1; arg_data = vecs[v].t[k]; arg_last = vecs[v].last[k];
            end
            @(negedge clk);
            arg_valid = 1'b0; arg_last = 1'b0;
            check("vec_res_valid", 32'(res_valid), 32'd1);
            check("vec_res_data", res_data, vecs[v].d);
            check("vec_res_sat", 32'(res_sat), 32'(vecs[v].s));
            @(negedge clk);
            check("vec_valid_one_cycle", 32'(res_valid), 32'd0);
            check("vec_ready_back", 32'(arg_ready), 32'd1);
            $display("vec %0d: n=%0d data=0x%08h sat=%0b", v, vecs[v].n, res_data, res_sat);
        end

        // Consumer stall: result held, a pending term waits for the handshake.
        res_ready = 1'b0;
        @(negedge clk); arg_valid = 1'b1; arg_data = 32'h100; arg_last = 1'b0;
        @(negedge clk); arg_data = 32'h200; arg_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_arg_ready", 32'(arg_ready), 32'd0);
            check("stall_res_data", res_data, 32'h300);
            arg_valid = 1'b1; arg_data = 32'h999; arg_last = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", 32'(arg_ready), 32'd1);
        check("stall_release_valid", 32'(res_valid), 32'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); arg_data = 32'h1;
        end
        @(negedge clk);
        arg_valid = 1'b0;
        check("stall_next_valid", 32'(res_valid), 32'd1);
        check("stall_next_data", res_data, 32'h99c);
        $display("stall: next sum data=0x%08h", res_data);
        @(negedge clk);

        // Reset in the middle of a sum discards the partial result.
        @(negedge clk); arg_valid = 1'b1; arg_data = 32'h100;
        @(negedge clk);
        @(negedge clk); arg_valid = 1'b0; rst_n = 1'b0;
        #1;
        check("midreset_res_data", res_data, 32'd0);
        check("midreset_arg_ready", 32'(arg_ready), 32'd1);
        check("midreset_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midreset_no_early", 32'(res_valid), 32'd0);
            arg_valid = 1'b1; arg_data = 32'h1;
        end
        @(negedge clk);
        arg_valid = 1'b0;
        check("midreset_valid", 32'(res_valid), 32'd1);
        check("midreset_data", res_data, 32'h4);
        $display("midreset: data=0x%08h", res_data);
        @(negedge clk);

        // Random stalls on both sides against the reference model.
        q = {};
        pending = 1'b0;
        sums_done = 0;
        cycles = 0;
        exp_d = '0; exp_s = 1'b0;
        while (sums_done < 100 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            check("rnd_arg_ready", 32'(arg_ready), 32'(!pending));
            check("rnd_res_valid", 32'(res_valid), 32'(pending));
            if (pending) begin
                check("rnd_res_data", res_data, exp_d);
                check("rnd_res_sat", 32'(res_sat), 32'(exp_s));
            end
            arg_valid = ($urandom_range(0, 3) != 0);
            arg_data  = rand_term();
            arg_last  = ($urandom_range(0, 4) == 0);
            res_ready = ($urandom_range(0, 2) != 0);
            if (!pending) begin
                if (arg_valid) begin
                    q.push_back(arg_data);
                    if (arg_last || q.size() == N) begin
                        model_sum(q, exp_d, exp_s);
                        q = {};
                        pending = 1'b1;
                    end
                end
            end else if (res_ready) begin
                $display("rnd sum %0d: data=0x%08h sat=%0b", sums_done, exp_d, exp_s);
                pending = 1'b0;
                sums_done++;
            end
        end
        arg_valid = 1'b0;
        check("rnd_sums_completed", 32'(sums_done), 32'd100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
